// File: rtl/pipe_ctrl_sequencer.sv
// Pipeline stall/flush sequencer: resolves hazard, memory-busy and HALT requests into
// per-stage write-enable/flush/bubble controls, sequences the halt drain and dmem timeout.
module pipe_ctrl_sequencer #(
  parameter int HALT_DRAIN_CYC = 3,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_use_i,
  input  logic        br_taken_i,
  input  logic        halt_dec_i,
  input  logic        imem_stall_i,
  input  logic        dmem_stall_i,
  output logic        pc_we_o,
  output logic        ifid_we_o,
  output logic        ifid_flush_o,
  output logic        idex_we_o,
  output logic        idex_nop_o,
  output logic        exmem_we_o,
  output logic        memwb_bubble_o,
  output logic        halted_o,
  output logic        err_o,
  output logic [2:0]  state_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DSTALL = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(HALT_DRAIN_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e             state_q, state_d, resume_q, resume_d, eff_s;
  logic [CNT_W-1:0]   tmo_q, tmo_d, drain_q, drain_d;
  logic [15:0]        stall_q, stall_d;
  logic               pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s;
  logic               idex_nop_s, exmem_we_s, memwb_bubble_s;

  // A DSTALL whose memory has just released behaves as the resumed state this same cycle.
  always_comb begin
    eff_s = state_q;
    if ((state_q == ST_DSTALL) && !dmem_stall_i) begin
      eff_s = resume_q;
    end else begin
      eff_s = state_q;
    end
  end

  always_comb begin
    pc_we_s        = 1'b0;
    ifid_we_s      = 1'b0;
    ifid_flush_s   = 1'b0;
    idex_we_s      = 1'b0;
    idex_nop_s     = 1'b0;
    exmem_we_s     = 1'b0;
    memwb_bubble_s = 1'b0;
    if (rst_i) begin
      pc_we_s = 1'b0;
    end else begin
      case (eff_s)
        ST_RUN: begin
          if (dmem_stall_i) begin
            memwb_bubble_s = 1'b1;
          end else begin
            pc_we_s    = 1'b1;
            ifid_we_s  = 1'b1;
            idex_we_s  = 1'b1;
            exmem_we_s = 1'b1;
            if (ld_use_i) begin
              pc_we_s    = 1'b0;
              ifid_we_s  = 1'b0;
              idex_nop_s = 1'b1;
            end else if (br_taken_i) begin
              ifid_flush_s = 1'b1;
            end else if (halt_dec_i || imem_stall_i) begin
              pc_we_s      = 1'b0;
              ifid_flush_s = 1'b1;
            end else begin
              pc_we_s = 1'b1;
            end
          end
        end
        ST_DSTALL: memwb_bubble_s = 1'b1;
        ST_DRAIN: begin
          if (dmem_stall_i) begin
            memwb_bubble_s = 1'b1;
          end else begin
            ifid_we_s    = ~ld_use_i;
            ifid_flush_s = 1'b1;
            idex_we_s    = 1'b1;
            idex_nop_s   = ld_use_i;
            exmem_we_s   = 1'b1;
          end
        end
        ST_HALTED, ST_ERR: pc_we_s = 1'b0;
        default:           pc_we_s = 1'b0;
      endcase
    end
  end

  // Next-state, drain/timeout counters and stall statistics.
  always_comb begin
    state_d  = eff_s;
    resume_d = resume_q;
    tmo_d    = '0;
    drain_d  = drain_q;
    case (eff_s)
      ST_RUN: begin
        if (dmem_stall_i) begin
          state_d  = ST_DSTALL;
          resume_d = ST_RUN;
          tmo_d    = CNT_ONE;
        end else if (halt_dec_i && !ld_use_i && !br_taken_i) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DSTALL: begin
        if (tmo_q >= TMO_LAST) begin
          state_d = ST_ERR;
          tmo_d   = tmo_q;
        end else begin
          tmo_d   = tmo_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (dmem_stall_i) begin
          state_d  = ST_DSTALL;
          resume_d = ST_DRAIN;
          tmo_d    = CNT_ONE;
        end else if (drain_q <= CNT_ONE) begin
          state_d = ST_HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q - CNT_ONE;
        end
      end
      ST_HALTED, ST_ERR: state_d = eff_s;
      default:           state_d = ST_ERR;
    endcase

    if (((eff_s == ST_RUN) || (eff_s == ST_DSTALL)) && !pc_we_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      resume_q <= ST_RUN;
      tmo_q    <= '0;
      drain_q  <= '0;
      stall_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      tmo_q    <= tmo_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
    end
  end

  assign pc_we_o        = pc_we_s;
  assign ifid_we_o      = ifid_we_s;
  assign ifid_flush_o   = ifid_flush_s;
  assign idex_we_o      = idex_we_s;
  assign idex_nop_o     = idex_nop_s;
  assign exmem_we_o     = exmem_we_s;
  assign memwb_bubble_o = memwb_bubble_s;
  assign halted_o       = (state_q == ST_HALTED);
  assign err_o          = (state_q == ST_ERR);
  assign state_o        = eff_s;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Self-checking bench for pipe_ctrl_sequencer: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model of the sequencer.
module tb_pipe_ctrl_sequencer;

  localparam int HDC = 3;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, ld_use, br_taken, halt_dec, imem_stall, dmem_stall;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_nop, exmem_we, memwb_bubble;
  logic        halted, err;
  logic [2:0]  state;
  logic [15:0] stall_cycles;
  logic [11:0] obs_w;

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model: mode 0=run 1=drain 2=halted 3=err
  int mode = 0, mem_wait = 0, drain_left = 0, stalls = 0;
  logic [11:0] exp_v;
  logic        exp_pw;

  pipe_ctrl_sequencer #(.HALT_DRAIN_CYC(HDC), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .ld_use_i(ld_use), .br_taken_i(br_taken),
    .halt_dec_i(halt_dec), .imem_stall_i(imem_stall), .dmem_stall_i(dmem_stall),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
    .idex_we_o(idex_we), .idex_nop_o(idex_nop), .exmem_we_o(exmem_we),
    .memwb_bubble_o(memwb_bubble), .halted_o(halted), .err_o(err),
    .state_o(state), .stall_cycles_o(stall_cycles)
  );

  assign obs_w = {pc_we, ifid_we, ifid_flush, idex_we, idex_nop, exmem_we, memwb_bubble,
                  halted, err, state};

  always #5 clk = ~clk;

  task automatic model_outputs();
    logic pw, iw, fl, xw, nop, mw, bub;
    logic [2:0] st;
    {pw, iw, fl, xw, nop, mw, bub} = 7'b0;
    if (mode >= 2) begin
      bub = 1'b0;
    end else if (dmem_stall) begin
      bub = 1'b1;
    end else if (mode == 0) begin
      {pw, iw, xw, mw} = 4'b1111;
      if (ld_use) begin pw = 1'b0; iw = 1'b0; nop = 1'b1; end
      else if (br_taken) fl = 1'b1;
      else if (halt_dec || imem_stall) begin pw = 1'b0; fl = 1'b1; end
    end else begin
      {iw, xw, mw, fl} = 4'b1111;
      if (ld_use) begin iw = 1'b0; nop = 1'b1; end
    end
    if (rst) {pw, iw, fl, xw, nop, mw, bub} = 7'b0;
    if (mode == 3) st = 3'd4;
    else if (mode == 2) st = 3'd3;
    else if (dmem_stall && mem_wait > 0) st = 3'd1;
    else if (mode == 1) st = 3'd2;
    else st = 3'd0;
    exp_pw = pw;
    exp_v  = {pw, iw, fl, xw, nop, mw, bub, (mode == 2), (mode == 3), st};
  endtask

  task automatic model_advance();
    if (rst) begin
      mode = 0; mem_wait = 0; drain_left = 0; stalls = 0;
    end else if (mode < 2) begin
      if (!exp_pw && (mode == 0 || (dmem_stall && mem_wait > 0)) && stalls < 65535)
        stalls++;
      if (dmem_stall) begin
        mem_wait++;
        if (mem_wait >= TMO) mode = 3;
      end else begin
        mem_wait = 0;
        if (mode == 0 && halt_dec && !ld_use && !br_taken) begin
          mode = 1; drain_left = HDC;
        end else if (mode == 1) begin
          drain_left--;
          if (drain_left <= 0) mode = 2;
        end
      end
    end
  endtask

  // Inputs change just after a rising edge; outputs are read at the falling edge.
  task automatic apply(input logic r, l, b, h, im, dm);
    rst = r; ld_use = l; br_taken = b; halt_dec = h; imem_stall = im; dmem_stall = dm;
    @(negedge clk);
    model_outputs();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== 12'b110101000000) begin
      n_fail++; $display("FAIL reset_outputs: got %b exp %b", obs_w, 12'b110101000000);
    end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cycles);
    end
    finish_cycle();
  endtask

  task automatic test_load_use();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== exp_v || pc_we !== 1'b0 || idex_nop !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall: got %b exp %b", obs_w, exp_v);
    end
    finish_cycle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== exp_v || stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL load_use_after: got %b/%0d exp %b/1", obs_w, stall_cycles, exp_v);
    end
    finish_cycle();
  endtask

  task automatic test_ld_br();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== exp_v || ifid_flush !== 1'b0) begin
      n_fail++; $display("FAIL ld_beats_br: got %b exp %b", obs_w, exp_v);
    end
    finish_cycle();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== exp_v || pc_we !== 1'b1 || ifid_flush !== 1'b1) begin
      n_fail++; $display("FAIL br_flush: got %b exp %b", obs_w, exp_v);
    end
    finish_cycle();
  endtask

  task automatic test_dstall();
    for (int c = 1; c <= 5; c++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (c <= 4));
      n_cmp++;
      if (obs_w !== exp_v || stall_cycles !== 16'(stalls)) begin
        n_fail++; $display("FAIL dstall_c%0d: got %b/%0d exp %b/%0d", c, obs_w, stall_cycles, exp_v, stalls);
      end
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if (state !== 3'd1 || memwb_bubble !== 1'b1) begin
          n_fail++; $display("FAIL dstall_state_c%0d: got %0d exp 1", c, state);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= 12; c++) begin
      apply((c == 12), 1'b0, 1'b0, 1'b0, 1'b0, (c <= 8));
      n_cmp++;
      if (obs_w !== exp_v) begin
        n_fail++; $display("FAIL timeout_c%0d: got %b exp %b", c, obs_w, exp_v);
      end
      if (c == 9) begin
        n_cmp++;
        if (err !== 1'b1 || state !== 3'd4) begin
          n_fail++; $display("FAIL timeout_err: got err=%b st=%0d exp err=1 st=4", err, state);
        end
      end
      finish_cycle();
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== exp_v || err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_rst_clear: got %b exp %b", obs_w, exp_v);
    end
    finish_cycle();
  endtask

  task automatic test_halt_drain();
    logic dm;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 1; c <= 8; c++) begin
        dm = (pass == 1) && (c == 3 || c == 4);
        apply((c == 8), 1'b0, 1'b0, (c == 1), 1'b0, dm);
        n_cmp++;
        if (obs_w !== exp_v || stall_cycles !== 16'(stalls)) begin
          n_fail++; $display("FAIL halt_p%0d_c%0d: got %b/%0d exp %b/%0d", pass, c, obs_w, stall_cycles, exp_v, stalls);
        end
        if (c == 5 + 2 * pass || c == 4 + 2 * pass) begin
          n_cmp++;
          if (halted !== (c == 5 + 2 * pass)) begin
            n_fail++; $display("FAIL halt_time_p%0d_c%0d: got %b exp %b", pass, c, halted, (c == 5 + 2 * pass));
          end
        end
        finish_cycle();
      end
    end
  endtask

  task automatic test_rst_drain();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_cycle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL drain_state: got %0d exp 2", state);
    end
    finish_cycle();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_cycle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_w !== 12'b110101000000 || stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL rst_in_drain: got %b/%0d exp %b/0", obs_w, stall_cycles, 12'b110101000000);
    end
    finish_cycle();
  endtask

  task automatic test_random();
    int burst;
    logic r, l, b, h, im, dm;
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 10);
      dm = (burst > 0);
      if (burst > 0) burst--;
      l  = ($urandom_range(0, 4) == 0);
      b  = ($urandom_range(0, 4) == 0);
      h  = ($urandom_range(0, 14) == 0);
      im = ($urandom_range(0, 4) == 0);
      apply(r, l, b, h, im, dm);
      n_cmp++;
      if (obs_w !== exp_v || stall_cycles !== 16'(stalls)) begin
        n_fail++; $display("FAIL random_%0d: got %b/%0d exp %b/%0d", i, obs_w, stall_cycles, exp_v, stalls);
      end
      finish_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; ld_use = 1'b0; br_taken = 1'b0; halt_dec = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0;
    #1;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_cycle();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_cycle();
    test_reset();
    test_load_use();
    test_ld_br();
    test_dstall();
    test_timeout();
    test_halt_drain();
    test_rst_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
